// File: rtl/ldtu_seq_pkg.sv
// Shared types and defaults for the LiTE-DTU link sequencer.
// State encodings, default parameters and the loss counter width.
package ldtu_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_HOLD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_SYNC  = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERROR = 3'd5
    } seq_state_e;

    localparam int DEF_NBITS          = 32;
    localparam int DEF_FLUSH_CYCLES   = 8;
    localparam int DEF_SYNCH_WORDS    = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int DEF_CNT_BITS       = 10;
    localparam int DEF_LOSS_THRESHOLD = 4;

    localparam int LOSS_W = 8;

endpackage

// File: rtl/ldtu_seq_timer.sv
// Sequence counter shared by the flush, synch and lock-timeout phases.
// Clears synchronously and stops at all-ones instead of wrapping.
module ldtu_seq_timer
    import ldtu_seq_pkg::*;
#(
    parameter int FlushCycles   = DEF_FLUSH_CYCLES,
    parameter int SynchWords    = DEF_SYNCH_WORDS,
    parameter int TimeoutCycles = DEF_TIMEOUT_CYCLES,
    parameter int CntBits       = DEF_CNT_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic flush_done,
    output logic sync_min,
    output logic sync_timeout
);

    logic [CntBits-1:0] count;

    // Up-counter, cleared on every state entry, held at its maximum.
    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (count != {CntBits{1'b1}})
            count <= count + 1'b1;
    end

    assign flush_done   = (count == CntBits'(FlushCycles - 1));
    assign sync_min     = (count >= CntBits'(SynchWords - 1));
    assign sync_timeout = (count == CntBits'(TimeoutCycles - 1));

endmodule

// File: rtl/ldtu_link_sequencer.sv
// Bring-up / re-sync sequencer for the LiTE-DTU transmit datapath.
// Optional auto-flush on sustained data loss: LDTU_SEQ_AUTOFLUSH_EN.
module ldtu_link_sequencer
    import ldtu_seq_pkg::*;
#(
    parameter int Nbits_32      = DEF_NBITS,
    parameter int FlushCycles   = DEF_FLUSH_CYCLES,
    parameter int SynchWords    = DEF_SYNCH_WORDS,
    parameter int TimeoutCycles = DEF_TIMEOUT_CYCLES,
    parameter int CntBits       = DEF_CNT_BITS,
    parameter int LossThreshold = DEF_LOSS_THRESHOLD
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                calib_busy,
    input  logic                test_enable,
    input  logic                flush_req,
    input  logic                resync_req,
    input  logic                handshake,
    input  logic                losing_data,
    input  logic [Nbits_32-1:0] synch_pattern_cfg,
    output logic                dp_en,
    output logic                flush,
    output logic                synch,
    output logic [Nbits_32-1:0] synch_pattern,
    output logic                link_ready,
    output logic                timeout_err,
    output logic [LOSS_W-1:0]   loss_cnt,
    output logic [2:0]          seq_state
);

    seq_state_e state;
    seq_state_e state_n;
    logic       restart;
    logic       clr;
    logic       flush_done;
    logic       sync_min;
    logic       sync_timeout;
    logic       auto_flush;

    ldtu_seq_timer #(
        .FlushCycles  (FlushCycles),
        .SynchWords   (SynchWords),
        .TimeoutCycles(TimeoutCycles),
        .CntBits      (CntBits)
    ) u_timer (
        .clk         (CLK),
        .rst         (RST),
        .clr         (clr),
        .flush_done  (flush_done),
        .sync_min    (sync_min),
        .sync_timeout(sync_timeout)
    );

    // A same-state restart still needs a fresh count.
    assign clr       = (state_n != state) || restart;
    assign seq_state = state;

`ifdef LDTU_SEQ_AUTOFLUSH_EN
    logic [LOSS_W-1:0] loss_run;

    // Consecutive losing_data cycles while in RUN.
    always_ff @(posedge CLK) begin
        if (RST || state != ST_RUN || !losing_data)
            loss_run <= '0;
        else if (loss_run != {LOSS_W{1'b1}})
            loss_run <= loss_run + 1'b1;
    end

    assign auto_flush = (loss_run >= LOSS_W'(LossThreshold));
`else
    assign auto_flush = 1'b0 && (LossThreshold > 0);
`endif

    // Next-state selection; global requests take priority.
    always_comb begin
        state_n = state;
        restart = 1'b0;
        if (state == ST_RESET) begin
            state_n = ST_HOLD;
        end else if (calib_busy || test_enable) begin
            state_n = ST_HOLD;
        end else if (flush_req && state != ST_HOLD) begin
            state_n = ST_FLUSH;
            restart = 1'b1;
        end else if (auto_flush && state == ST_RUN) begin
            state_n = ST_FLUSH;
        end else if (resync_req &&
                     (state == ST_RUN || state == ST_ERROR)) begin
            state_n = ST_SYNC;
        end else if (resync_req && state == ST_SYNC) begin
            restart = 1'b1;
        end else begin
            case (state)
                ST_HOLD:  state_n = ST_FLUSH;
                ST_FLUSH: if (flush_done) state_n = ST_SYNC;
                ST_SYNC: begin
                    if (sync_min && handshake)
                        state_n = ST_RUN;
                    else if (sync_timeout)
                        state_n = ST_ERROR;
                end
                ST_RUN:   state_n = ST_RUN;
                ST_ERROR: state_n = ST_ERROR;
                default:  state_n = ST_RESET;
            endcase
        end
    end

    // State register plus registered output decode of the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_RESET;
            dp_en      <= 1'b0;
            flush      <= 1'b0;
            synch      <= 1'b0;
            link_ready <= 1'b0;
        end else begin
            state      <= state_n;
            dp_en      <= (state_n == ST_FLUSH) || (state_n == ST_SYNC) ||
                          (state_n == ST_RUN)   || (state_n == ST_ERROR);
            flush      <= (state_n == ST_FLUSH);
            synch      <= (state_n == ST_SYNC) || (state_n == ST_ERROR);
            link_ready <= (state_n == ST_RUN);
        end
    end

    // Pattern latch, sticky timeout flag and saturating loss count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            synch_pattern <= '0;
            timeout_err   <= 1'b0;
            loss_cnt      <= '0;
        end else begin
            if (state_n == ST_SYNC && state != ST_SYNC)
                synch_pattern <= synch_pattern_cfg;
            if (state == ST_SYNC && state_n == ST_ERROR)
                timeout_err <= 1'b1;
            if (state_n == ST_FLUSH && state != ST_FLUSH)
                loss_cnt <= '0;
            else if (state == ST_RUN && losing_data &&
                     loss_cnt != {LOSS_W{1'b1}})
                loss_cnt <= loss_cnt + 1'b1;
        end
    end

endmodule
